mem_sram_stage: RTL
===================

// Module: mem_sram_stage
// PURPOSE
//  Memory stage sitting directly after the execute stage. Consumes the execute results (ALU result as
//  address, forwarded Rm value as store data, memory enables) and runs a multi-cycle access on an
//  external word SRAM. It stalls the pipeline via ready while busy, then loads the MEM/WB register.
// PARAMETERS
//  WAIT_CYCLES  5     SRAM access length in clock cycles (>=1); read data is sampled on the last one
//  BASE_ADDR    1024  byte address mapped to SRAM word 0
//  ADDR_W       16    SRAM word-address width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  wb_en_in     in   1       instruction writes back a register
//  mem_r_en_in  in   1       load
//  mem_w_en_in  in   1       store
//  dest_in      in   4       destination register number
//  alu_res_in   in   32      ALU result (byte address for load/store)
//  st_val_in    in   32      store data (forwarded Rm)
//  ready        out  1       1 = stage can advance this cycle; 0 = freeze all earlier pipeline regs
//  sram_addr    out  ADDR_W  SRAM word address
//  sram_wdata   out  32      SRAM write data
//  sram_rdata   in   32      SRAM read data
//  sram_we_n    out  1       SRAM write strobe, active low
//  wb_en_out    out  1       MEM/WB register: wb_en
//  mem_r_en_out out  1       MEM/WB register: load flag (WB mux select)
//  dest_out     out  4       MEM/WB register: destination
//  alu_res_out  out  32      MEM/WB register: ALU result
//  mem_data_out out  32      MEM/WB register: load data
// BEHAVIOUR
//  - mem_op = mem_r_en_in | mem_w_en_in. Both set: treat as store, no load data.
//  - Address: off = alu_res_in - BASE_ADDR (32-bit, mod 2^32); sram_addr = off[ADDR_W+1:2] (bits[1:0] ignored).
//    sram_addr/sram_wdata are driven combinationally from the inputs at all times.
//  - FSM states are IDLE, ACCESS and DONE; a counter cnt of clog2(WAIT_CYCLES) bits.
//    IDLE:   ready = ~mem_op. On mem_op, go to ACCESS with cnt=0; otherwise stay in IDLE.
//    ACCESS: ready=0. sram_we_n = ~mem_w_en_in (low throughout, stores only). cnt++ each cycle.
//            When cnt==WAIT_CYCLES-1: capture sram_rdata into rdata_q (loads), then go to DONE.
//    DONE:   ready=1, sram_we_n=1. Go to IDLE unconditionally.
//  - sram_we_n=1 in IDLE and DONE.
//  - A memory op therefore holds ready low for WAIT_CYCLES+1 cycles, then high for 1 cycle.
//    Non-memory ops: ready=1, so they take 1 cycle.
//  - Inputs stay stable while ready=0 (upstream frozen). The block does not re-check them mid-access.
//  - MEM/WB register loads only on edges where ready=1, and holds otherwise. Fields loaded:
//      wb_en_out    <= wb_en_in & ~mem_w_en_in
//      mem_r_en_out <= mem_r_en_in & ~mem_w_en_in
//      dest_out     <= dest_in
//      alu_res_out  <= alu_res_in
//      mem_data_out <= rdata_q (loads) or 0
//  - Back-to-back memory ops: after DONE->IDLE the next op is presented at once, so ready drops again
//    in that IDLE cycle. There are no idle gaps beyond the DONE cycle.
//  - Reset, including mid-access: state=IDLE, cnt=0, rdata_q=0, all MEM/WB outputs 0, sram_we_n=1.
//    Any in-flight store is abandoned; the SRAM word content is undefined.
// TESTING (WAIT_CYCLES=5, BASE_ADDR=1024)
//  1 Store alu_res_in=1024, st_val_in=0x12345678 -> sram_addr=0, sram_we_n low exactly 5 cycles,
//    ready low 6 cycles then high 1; wb_en_out=0 after the load edge.
//  2 Load from 1028 after storing 0xDEADBEEF there -> sram_addr=1, sram_we_n stays 1, 7 cycles total;
//    mem_data_out=0xDEADBEEF, mem_r_en_out=1.
//  3 Three ALU ops (wb_en=1, dest 1,2,3) back-to-back -> ready constantly 1, one MEM/WB update per cycle,
//    mem_data_out=0.
//  4 Store then load at once (1032) -> two 7-cycle windows with a single-cycle ready pulse between;
//    load returns the stored value.
//  5 rst asserted at cycle 3 of a store -> next edge: ready=~mem_op, sram_we_n=1, all outputs 0, FSM in IDLE.
//  6 Both enables set, alu_res_in=1036 -> handled as store, wb_en_out=0, mem_r_en_out=0.

Source files
------------

// File: rtl/mem_sram_stage.sv
// Memory stage: multi-cycle access to an external word SRAM, then loads the MEM/WB register.
// Memory ops stall upstream via ready for WAIT_CYCLES+1 cycles; non-memory ops pass in one cycle.
module mem_sram_stage #(
  parameter int WAIT_CYCLES = 5,
  parameter int BASE_ADDR   = 1024,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [3:0]        dest_in,
  input  logic [31:0]       alu_res_in,
  input  logic [31:0]       st_val_in,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_we_n,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [3:0]        dest_out,
  output logic [31:0]       alu_res_out,
  output logic [31:0]       mem_data_out
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      rdata_q;
  logic [31:0]      off;
  logic             mem_op;
  logic             is_load;
  logic             capture;
  logic             unused_off_bits;

  assign mem_op  = mem_r_en_in | mem_w_en_in;
  // A store wins when both enables are set, so a load needs the write enable clear.
  assign is_load = mem_r_en_in & ~mem_w_en_in;

  assign off             = alu_res_in - 32'(BASE_ADDR);
  assign sram_addr       = off[ADDR_W+1:2];
  assign sram_wdata      = st_val_in;
  assign unused_off_bits = ^{off[31:ADDR_W+2], off[1:0]};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ready     = 1'b1;
    sram_we_n = 1'b1;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        ready = ~mem_op;
        if (mem_op) begin
          state_nxt = ACCESS;
          cnt_nxt   = '0;
        end
      end
      ACCESS: begin
        ready     = 1'b0;
        sram_we_n = ~mem_w_en_in;
        cnt_nxt   = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rdata_q      <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      dest_out     <= '0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture && is_load) begin
        rdata_q <= sram_rdata;
      end
      if (ready) begin
        wb_en_out    <= wb_en_in & ~mem_w_en_in;
        mem_r_en_out <= is_load;
        dest_out     <= dest_in;
        alu_res_out  <= alu_res_in;
        mem_data_out <= is_load ? rdata_q : 32'd0;
      end
    end
  end

endmodule
